serial_sub_cla: RTL and testbench

- Digit-serial unsigned/two's-complement subtractor, the inverse datapath to the team's 4-bit carry-lookahead adder slice.
- Computes diff = a - b - bin over WIDTH bits, one 4-bit nibble per cycle, LSB nibble first.
- Each nibble uses an internal 4-bit CLA slice in the form a + ~b + carry, where carry = ~borrow.
- Sits in the arithmetic test datapath between a valid/ready producer and a valid/ready consumer.

---
 rtl/serial_sub_cla.sv | 114 +++++++++++
 tb/tb_serial_sub_cla.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_cla.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit CLA slice per cycle, LSB nibble first.
// Results and flags are registered and held until the consumer takes them.
module serial_sub_cla #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("serial_sub_cla: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // CALC  | one nibble of a + ~b + carry per cycle
    // DONE  | result and flags valid, held until out_ready
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r;
    logic             carry;
    logic             accept, last;
    logic [3:0]       an, bn, g, p, sum;
    logic [4:0]       c;
    logic [WIDTH-1:0] diff_nx;

    assign an = a_r[4*cnt +: 4];
    assign bn = b_r[4*cnt +: 4];

    // subtraction as addition of the inverted subtrahend; carry is the inverted borrow
    always_comb begin
        g    = an & ~bn;
        p    = an ^ ~bn;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
        diff_nx = diff;
        diff_nx[4*cnt +: 4] = sum;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = (cnt == CW'(NIB - 1));
        case (state)
            IDLE: if (in_valid && in_ready) begin
                accept   = 1'b1;
                state_nx = CALC;
            end
            CALC: if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                carry <= ~bin;
                cnt   <= '0;
            end
            if (state == CALC) begin
                diff  <= diff_nx;
                carry <= c[4];
                cnt   <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    bout <= ~c[4];
                    ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_nx[WIDTH-1] != a_r[WIDTH-1]);
                    zero <= (diff_nx == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_cla.sv
// Bench for serial_sub_cla: directed cases on a 16-bit instance plus randomized
// traffic on 4/16/32-bit instances against an integer reference model.
module tb_serial_sub_cla;

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [3];
    logic        out_ready_s [3];
    logic [31:0] a_s [3];
    logic [31:0] b_s [3];
    logic        bin_s [3];
    wire         in_ready_w  [3];
    wire         out_valid_w [3];
    wire         bout_w [3];
    wire         ovf_w  [3];
    wire         zero_w [3];
    wire [3:0]   d4;
    wire [15:0]  d16;
    wire [31:0]  d32;

    int passed = 0;
    int total  = 0;

    serial_sub_cla #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
        .a(a_s[0][3:0]), .b(b_s[0][3:0]), .bin(bin_s[0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready_s[0]), .diff(d4), .bout(bout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]));

    serial_sub_cla #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
        .a(a_s[1][15:0]), .b(b_s[1][15:0]), .bin(bin_s[1]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready_s[1]), .diff(d16), .bout(bout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]));

    serial_sub_cla #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]),
        .a(a_s[2]), .b(b_s[2]), .bin(bin_s[2]), .out_valid(out_valid_w[2]),
        .out_ready(out_ready_s[2]), .diff(d32), .bout(bout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]));

    always #5 clk = ~clk;

    function automatic logic [31:0] get_diff(input int idx);
        case (idx)
            0:       return {28'd0, d4};
            1:       return {16'd0, d16};
            default: return d32;
        endcase
    endfunction

    // integer reference: subtract in wide signed arithmetic, then reduce
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input bit bi, output logic [31:0] d, output bit bo,
                                  output bit ov, output bit z);
        longint m, ua, ub, r, sa, sb, sr;
        m  = longint'(1) << w;
        ua = longint'(av);
        ub = longint'(bv);
        r  = ua - ub - longint'(bi);
        bo = (r < 0);
        d  = 32'(((r % m) + m) % m);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sr = sa - sb - longint'(bi);
        ov = (sr < -(m / 2)) || (sr >= m / 2);
        z  = (d == 0);
    endfunction

    // producer/consumer driver for one instance; entered and left at #1 after a rising edge
    task automatic do_op(input int idx, input logic [31:0] av, input logic [31:0] bv, input bit bi,
                         input int gap, input int hold, output logic [31:0] d, output bit bo,
                         output bit ov, output bit z, output int lat, output bit ok, output bit hs);
        bit acc;
        int n;
        ok = 1; hs = 1; lat = 0; d = '0; bo = 0; ov = 0; z = 0;
        repeat (gap) begin @(posedge clk); #1; end
        a_s[idx] = av; b_s[idx] = bv; bin_s[idx] = bi; in_valid_s[idx] = 1'b1;
        n = 0;
        do begin
            acc = in_ready_w[idx];
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        in_valid_s[idx] = 1'b0;
        a_s[idx] = $urandom; b_s[idx] = $urandom;
        out_ready_s[idx] = 1'($urandom_range(0, 1));
        if (!acc) begin ok = 0; return; end
        while (!out_valid_w[idx] && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!out_valid_w[idx]) begin ok = 0; return; end
        d = get_diff(idx); bo = bout_w[idx]; ov = ovf_w[idx]; z = zero_w[idx];
        if (in_ready_w[idx] !== 1'b0) hs = 0;
        out_ready_s[idx] = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (out_valid_w[idx] !== 1'b1 || in_ready_w[idx] !== 1'b0 || get_diff(idx) !== d ||
                bout_w[idx] !== bo || ovf_w[idx] !== ov || zero_w[idx] !== z) hs = 0;
        end
        out_ready_s[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[idx] = 1'b0;
        if (out_valid_w[idx] !== 1'b0 || in_ready_w[idx] !== 1'b1) hs = 0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({in_ready_w[i], out_valid_w[i], bout_w[i], ovf_w[i], zero_w[i], get_diff(i)} !==
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0})
                $display("FAIL reset_state[%0d]: got rdy=%b vld=%b bo=%b ov=%b z=%b d=%h required rdy=1 others 0",
                         i, in_ready_w[i], out_valid_w[i], bout_w[i], ovf_w[i], zero_w[i], get_diff(i));
            else passed++;
        end
    endtask

    typedef struct {
        logic [15:0] a, b;
        bit          bin;
        logic [15:0] d;
        bit          bo, ov, z;
    } vec_t;

    task automatic test_directed;
        vec_t vecs [6];
        logic [31:0] d;
        bit bo, ov, z, ok, hs;
        int lat;
        vecs[0] = '{16'h1234, 16'h0034, 0, 16'h1200, 0, 0, 0};
        vecs[1] = '{16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0};
        vecs[2] = '{16'h0005, 16'h0005, 1, 16'hFFFF, 1, 0, 0};
        vecs[3] = '{16'h0005, 16'h0005, 0, 16'h0000, 0, 0, 1};
        vecs[4] = '{16'h8000, 16'h0001, 0, 16'h7FFF, 0, 1, 0};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            do_op(1, {16'd0, vecs[i].a}, {16'd0, vecs[i].b}, vecs[i].bin, 0, 0, d, bo, ov, z, lat, ok, hs);
            total++;
            if (!ok) $display("FAIL directed_timeout[%0d]: got no handshake required completion", i);
            else passed++;
            total++;
            if (lat !== 4) $display("FAIL directed_latency[%0d]: got %0d required 4", i, lat);
            else passed++;
            total++;
            if (d[15:0] !== vecs[i].d) $display("FAIL directed_diff[%0d]: got %h required %h", i, d[15:0], vecs[i].d);
            else passed++;
            total++;
            if ({bo, ov, z} !== {vecs[i].bo, vecs[i].ov, vecs[i].z})
                $display("FAIL directed_flags[%0d]: got bo/ov/z=%b%b%b required %b%b%b",
                         i, bo, ov, z, vecs[i].bo, vecs[i].ov, vecs[i].z);
            else passed++;
            total++;
            if (!hs) $display("FAIL directed_handshake[%0d]: got bad ready/valid sequence required clean", i);
            else passed++;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        a_s[1] = 32'h1234; b_s[1] = 32'h0034; bin_s[1] = 0;
        out_ready_s[1] = 0; in_valid_s[1] = 1;
        @(posedge clk); #1;
        in_valid_s[1] = 0;
        lat = 0;
        while (!out_valid_w[1] && lat < 50) begin @(posedge clk); #1; lat++; end
        total++;
        if (lat !== 4) $display("FAIL bp_latency: got %0d required 4", lat);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            in_valid_s[1] = (i == 1);
            a_s[1] = 32'hFFFF; b_s[1] = 32'h0000; bin_s[1] = 0;
            @(posedge clk); #1;
            total++;
            if ({out_valid_w[1], in_ready_w[1], d16, bout_w[1], ovf_w[1], zero_w[1]} !==
                {1'b1, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0})
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b d=%h flags=%b%b%b required vld=1 rdy=0 d=1200 flags=000",
                         i, out_valid_w[1], in_ready_w[1], d16, bout_w[1], ovf_w[1], zero_w[1]);
            else passed++;
        end
        in_valid_s[1] = 0;
        out_ready_s[1] = 1;
        @(posedge clk); #1;
        out_ready_s[1] = 0;
        total++;
        if ({out_valid_w[1], in_ready_w[1]} !== 2'b01)
            $display("FAIL bp_release: got vld=%b rdy=%b required vld=0 rdy=1", out_valid_w[1], in_ready_w[1]);
        else passed++;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if ({out_valid_w[1], in_ready_w[1], d16} !== {1'b0, 1'b1, 16'h1200})
            $display("FAIL bp_no_capture: got vld=%b rdy=%b d=%h required vld=0 rdy=1 d=1200",
                     out_valid_w[1], in_ready_w[1], d16);
        else passed++;
    endtask

    task automatic test_reset_midcalc;
        logic [31:0] d, ed;
        bit bo, ov, z, ok, hs, ebo, eov, ez;
        int lat;
        a_s[1] = 32'hABCD; b_s[1] = 32'h1111; bin_s[1] = 0; in_valid_s[1] = 1;
        @(posedge clk); #1;
        in_valid_s[1] = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        total++;
        if ({in_ready_w[1], out_valid_w[1], d16, bout_w[1], ovf_w[1], zero_w[1]} !==
            {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0})
            $display("FAIL midcalc_reset: got rdy=%b vld=%b d=%h flags=%b%b%b required rdy=1 vld=0 d=0000 flags=000",
                     in_ready_w[1], out_valid_w[1], d16, bout_w[1], ovf_w[1], zero_w[1]);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1;
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if ({out_valid_w[1], in_ready_w[1], d16} !== {1'b0, 1'b1, 16'h0000})
            $display("FAIL midcalc_discard: got vld=%b rdy=%b d=%h required vld=0 rdy=1 d=0000",
                     out_valid_w[1], in_ready_w[1], d16);
        else passed++;
        do_op(1, 32'h4321, 32'h1234, 1, 0, 1, d, bo, ov, z, lat, ok, hs);
        model(16, 32'h4321, 32'h1234, 1, ed, ebo, eov, ez);
        total++;
        if ({ok, hs, d, bo, ov, z} !== {1'b1, 1'b1, ed, ebo, eov, ez})
            $display("FAIL post_reset_op: got ok=%b hs=%b d=%h flags=%b%b%b required ok=1 hs=1 d=%h flags=%b%b%b",
                     ok, hs, d, bo, ov, z, ed, ebo, eov, ez);
        else passed++;
    endtask

    task automatic test_random_stream(input int idx, input int w, input int n);
        logic [31:0] mask, av, bv, d, ed;
        bit bi, bo, ov, z, ok, hs, ebo, eov, ez;
        int lat;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        for (int i = 0; i < n; i++) begin
            av = $urandom & mask;
            bv = $urandom & mask;
            case ($urandom_range(0, 7))
                0: bv = av;
                1: bv = (av + 32'd1) & mask;
                2: begin av = mask >> 1; bv = mask; end
                3: begin av = (mask >> 1) + 32'd1; bv = 32'd1; end
                default: ;
            endcase
            bi = 1'($urandom_range(0, 1));
            do_op(idx, av, bv, bi, $urandom_range(0, 2), $urandom_range(0, 2), d, bo, ov, z, lat, ok, hs);
            model(w, av, bv, bi, ed, ebo, eov, ez);
            total++;
            if (!ok || !hs) $display("FAIL rand_handshake_w%0d: got ok=%b hs=%b required 1 1", w, ok, hs);
            else passed++;
            total++;
            if (lat !== w / 4) $display("FAIL rand_latency_w%0d: got %0d required %0d", w, lat, w / 4);
            else passed++;
            total++;
            if ({d, bo, ov, z} !== {ed, ebo, eov, ez})
                $display("FAIL rand_result_w%0d: a=%h b=%h bin=%b got d=%h bo=%b ov=%b z=%b required d=%h bo=%b ov=%b z=%b",
                         w, av, bv, bi, d, bo, ov, z, ed, ebo, eov, ez);
            else passed++;
        end
    endtask

    initial begin
        clk = 0;
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid_s[i] = 0; out_ready_s[i] = 0; a_s[i] = '0; b_s[i] = '0; bin_s[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1;
        @(posedge clk); #1;
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_midcalc;
        fork
            test_random_stream(0, 4, 3334);
            test_random_stream(1, 16, 3333);
            test_random_stream(2, 32, 3333);
        join
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
